stage5_pack: RTL
================

Name: stage5_pack

Overview:
- Output stage of the SD4 MAC pipeline. It sits directly downstream of stage4, which normalizes the sum.
- Consumes stage4's registered sign, 11-bit normalized magnitude and signed exponent, and packs them into an IEEE-754 binary16 word.
- Handles subnormal and overflow cases, keeps sticky exception flags, and buffers results in a small FIFO behind a valid/ready handshake.

Parameters:
- BIAS, 15, exponent bias added to exp_final.
- DEPTH, 2, output FIFO entries (power of 2, at least 2).
- SAT_MAX, 0, overflow result: 0 gives ±Inf (exp=31, man=0); 1 gives ±max finite (16'h7BFF / 16'hFBFF).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  stage4 outputs hold a result to pack.
- in_ready  out  1  block can accept this cycle.
- sign  in  1  result sign.
- norm_sum  in  11  magnitude; bit10 is the hidden bit when nonzero.
- exp_final  in  7  signed, unbiased exponent.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  16  binary16 {s, e[4:0], m[9:0]}.
- flag_clr  in  1  clears the sticky flags.
- ovf_flag  out  1  sticky: at least one overflow packed.
- unf_flag  out  1  sticky: at least one subnormal or flushed-to-zero result packed.
- result_cnt  out  16  number of results popped; wraps.

Behaviour:
- Reset (asynchronous, rst=1):
  - FIFO count, read pointer and write pointer = 0.
  - out_valid=0, out_data=0, ovf_flag=0, unf_flag=0, result_cnt=0, in_ready=1 after release.
  - Reset asserted mid-operation discards all buffered results immediately.
- Handshake:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count < DEPTH). No combinational path from out_ready.
  - out_valid = (count != 0). out_data = FIFO head, driven directly from storage.
- Latency: a result accepted at edge N is visible on out_data with out_valid=1 after edge N, if the FIFO was empty.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, push is blocked because in_ready=0, even if out_ready=1.
- Pointers wrap modulo DEPTH. The FIFO holds no packed value that was not accepted.
- Packing (combinational on the inputs, written into the FIFO on accept):
  - be = sign-extended exp_final + BIAS, 8-bit signed.
  - norm_sum == 0: result {sign, 15'b0}. No flag is raised.
  - be >= 31: overflow; result per SAT_MAX; sets ovf_flag.
  - 1 <= be <= 30: result {sign, be[4:0], norm_sum[9:0]}.
  - be <= 0: subnormal.
    - sh = 1 - be. Mantissa = norm_sum >> sh, truncated (no rounding).
    - Result {sign, 5'b0, mant[9:0]}. If sh >= 11, mantissa = 0.
    - Sets unf_flag.
  - norm_sum != 0 with bit10 = 0 is an upstream protocol error. It is packed using the same rules without correction.
- Flags:
  - Set on the accept edge of the offending input.
  - flag_clr=1 clears both flags at the next edge.
  - Set and clear in the same cycle: set wins.
- result_cnt increments by 1 per pop and wraps 16'hFFFF to 0.

Test Plan:
- Reset → all outputs 0, in_ready=1. Push {0, 11'h400, exp 0}, out_ready=1 → next cycle out_data=16'h3C00, out_valid=1, result_cnt=1 after the pop.
- Push {1, 11'h600, exp 16}, SAT_MAX=0 → 16'hFC00, ovf_flag=1. Same input with SAT_MAX=1 → 16'hFBFF.
- Push {0, 11'h400, exp -14} → 16'h0400, no flag. Push exp -15 → 16'h0200, unf_flag=1. Push exp -25 → 16'h0000, unf_flag=1. Push norm_sum=0, exp 40 → 16'h0000, no flags.
- Backpressure: out_ready=0, push 3 results with DEPTH=2 → in_ready=0 after 2 accepts, 3rd held. Raise out_ready → output order preserved, 3rd accepted; push and pop in one cycle keeps count.
- ovf_flag=1, then assert flag_clr in the same cycle as a new overflow accept → flag stays 1. flag_clr alone → 0.
- Assert rst while the FIFO holds 2 entries → out_valid drops to 0 immediately, buffered results are lost, and result_cnt=0.

Source files
------------

// File: rtl/stage5_pack_if.sv
// Handshake and payload bundle between stage4, the binary16 packer and its consumer.
interface stage5_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  // Producer/consumer side
  modport master (
    output in_valid, sign, norm_sum, exp_final, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Packer side
  modport slave (
    input  in_valid, sign, norm_sum, exp_final, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stage5_pack.sv
// Output stage of the SD4 MAC: packs sign/normalized magnitude/exponent into binary16,
// keeps sticky overflow/underflow flags and buffers results in a small FIFO.
module stage5_pack #(
  parameter int unsigned BIAS    = 15,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SAT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst,
  stage5_pack_if.slave      bus,
  input  logic              flag_clr,
  output logic              ovf_flag,
  output logic              unf_flag,
  output logic [15:0]       result_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [15:0]       cnt_q, cnt_d;

  logic signed [7:0] be_c;
  logic [7:0]        sh_c;
  logic [9:0]        mant_c;
  logic [15:0]       pack_c;
  logic              ovf_c, unf_c;
  logic              in_ready_c, out_valid_c, push_c, pop_c;

  // Biased exponent; an 8-bit signed result covers the full 7-bit input range.
  assign be_c = $signed({exp_final_sx(bus.exp_final)}) + $signed(8'(BIAS));
  assign sh_c = 8'(8'sd1 - be_c);

  function automatic logic [7:0] exp_final_sx(input logic [6:0] e);
    return {e[6], e};
  endfunction

  // Binary16 packing of the current input
  always_comb begin
    pack_c = {bus.sign, 15'b0};
    mant_c = '0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    if (bus.norm_sum != 11'd0) begin
      if (be_c >= 8'sd31) begin
        ovf_c  = 1'b1;
        pack_c = (SAT_MAX != 0) ? {bus.sign, 15'h7BFF} : {bus.sign, 5'h1F, 10'h000};
      end else if (be_c >= 8'sd1) begin
        pack_c = {bus.sign, be_c[4:0], bus.norm_sum[9:0]};
      end else begin
        unf_c = 1'b1;
        if (sh_c < 8'd11) mant_c = 10'(bus.norm_sum >> sh_c[3:0]);
        pack_c = {bus.sign, 5'b0, mant_c};
      end
    end
  end

  assign in_ready_c  = (count_q < CW'(DEPTH));
  assign out_valid_c = (count_q != '0);
  assign push_c      = bus.in_valid & in_ready_c;
  assign pop_c       = out_valid_c & bus.out_ready;

  // Next-state for pointers, occupancy, flags and pop counter; a new set beats a clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    cnt_d    = cnt_q;
    ovf_d    = (ovf_q & ~flag_clr) | (push_c & ovf_c);
    unf_d    = (unf_q & ~flag_clr) | (push_c & unf_c);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      cnt_q    <= cnt_d;
      if (push_c) mem_q[wr_ptr_q] <= pack_c;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign ovf_flag      = ovf_q;
  assign unf_flag      = unf_q;
  assign result_cnt    = cnt_q;

endmodule
